encode_mul_arbiter: RTL and testbench
=====================================

# encode_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined signed multiplier (default 40-bit × 29-bit, 68-bit product) between N requesters in the encoder datapath. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `ce`, `din0` and `din1`. A valid/tag shadow pipeline runs in lockstep with the multiplier. Each product is returned on a single tagged result port with backpressure, which stalls the whole multiplier pipe.

## Interface
- `N`, 4: number of requesters (2..8).
- `A_W`, 40: width of operand A (signed).
- `B_W`, 29: width of operand B (signed).
- `P_W`, 68: product width, matching the multiplier `dout`.
- `MUL_LAT`, 1: number of `ce`-qualified register stages inside the multiplier (1..4).
- `TAG_W`, 2: requester index width, equal to clog2(N).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid`  in  N  per-requester operand valid.
- `req_ready`  out  N  per-requester accept; one-hot or zero.
- `req_a`  in  N*A_W  operand A, requester i at bits [i*A_W +: A_W].
- `req_b`  in  N*B_W  operand B, requester i at bits [i*B_W +: B_W].
- `mul_ce`  out  1  multiplier clock enable.
- `mul_din0`  out  A_W  multiplier operand 0.
- `mul_din1`  out  B_W  multiplier operand 1.
- `mul_dout`  in  P_W  multiplier product, registered.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumer accept.
- `res_tag`  out  TAG_W  index of the requester that owns `res_data`.
- `res_data`  out  P_W  product; equals `mul_dout`.
- `inflight`  out  3  number of valid entries in the shadow pipe (0..MUL_LAT).

## Operation
- **Shadow pipe.** MUL_LAT stages, each holding {v, tag}. It shifts only when `mul_ce`=1.
  - Stage 0 loads {grant_valid, grant_idx}.
  - `res_valid` = v of the last stage; `res_tag` = tag of the last stage.
- **Enable.** `mul_ce` = `reset` & (!`res_valid` | `res_ready`). Advancing is combinational; there is no skid buffer.
- **Arbitration.** Round-robin pointer `ptr` (TAG_W bits).
  - Grant goes to the first i with `req_valid[i]`=1, scanning ptr, ptr+1, …, ptr+N-1 mod N.
  - grant_valid = any `req_valid` & `mul_ce`.
  - `req_ready[grant_idx]` = grant_valid; all other bits are 0.
- **Pointer update.** On an accepted grant, `ptr` ← (grant_idx+1) mod N. With no grant, `ptr` holds.
- **Operand drive.** `mul_din0`/`mul_din1` = the granted requester's operands when grant_valid, else all zeros. The stage-0 v bit marks zero bubbles as invalid.
- **Arithmetic.** The multiplier computes the signed product truncated to P_W bits. The arbiter passes `mul_dout` through unchanged and does no sign handling of its own.
- **Result transfer.** A result transfers when `res_valid` & `res_ready`.
  - With `res_valid`=1 and `res_ready`=0: `mul_ce`=0, no grants are issued, and `res_data`/`res_tag`/`inflight` stay stable.
  - Simultaneous result transfer and new grant in the same cycle is required and is the normal steady state.
- **`inflight`.** Popcount of the shadow v bits, registered alongside the pipe.
- **Requester side.** A requester must hold `req_valid` and its operands until it sees `req_ready`. The arbiter never drops or reorders results: results emerge in grant order.

## Timing
- **Reset** (`reset`=0 at a clock edge):
  - All v bits ← 0; `ptr` ← 0.
  - During reset: `res_valid`=0, `inflight`=0, `req_ready`=0, `mul_ce`=0, `mul_din0`/`mul_din1`=0.
  - Reset asserted mid-operation discards all in-flight products without emitting them. Multiplier contents are don't-care because the v bits are cleared.
- **Latency.** A request accepted at edge T (valid&ready high in the cycle before T) has `res_valid`=1 in the cycle after edge T+MUL_LAT-1, given no stalls. For MUL_LAT=1, the result is visible in the cycle immediately after acceptance.
- **Throughput.** One grant per cycle while `res_ready`=1. Each stall cycle delays all in-flight entries by exactly one cycle.
- **First grant after reset release.** Requester 0 has priority.

## Test plan
- **Single request.** reset high; `req_valid`=0001, a=3, b=-5.
  - `req_ready`=0001 in the same cycle.
  - Next cycle: `res_valid`=1, `res_tag`=0, `res_data`=-15 (sign-extended to 68 bits), `inflight`=1.
- **Round-robin fairness.** `req_valid`=1111 held, `res_ready`=1 for 8 cycles.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `res_tag` sequence follows one cycle later; a requester's count differs from any other's by at most 1 at all times.
- **Backpressure.** Stream requester 2 with a=k (k=1..6), b=2; hold `res_ready`=0 for 3 cycles mid-stream.
  - `mul_ce`=0 and `req_ready`=0 during the stall, with `res_data` held.
  - Products 2,4,…,12 arrive in order with no loss or duplication.
- **Signed extremes.** a=-2^39, b=-2^28.
  - `res_data` has only bit 67 set, reading as -2^67 (truncation wrap).
  - a=2^39-1, b=-1 → `res_data`=-(2^39-1).
- **Reset mid-flight.** With `inflight`=1 and `res_ready`=0, drive `reset`=0 for one cycle.
  - Next cycle: `res_valid`=0, `inflight`=0, `ptr`=0.
  - After release, `req_valid`=1010 grants requester 1 first.
- **Pointer skip.** `ptr`=3 and `req_valid`=0100 → grant 2, then `ptr`=3. Next, `req_valid`=1001 → grant 3, then `ptr`=0.

Source files
------------

// File: rtl/encode_mul_arbiter.sv
// -----------------------------------------------------------------------------
// encode_mul_arbiter
//
// Round-robin arbiter/sequencer sharing one external pipelined signed
// multiplier between N requesters. Operand pairs are accepted over per-requester
// valid/ready handshakes. A {valid, tag} shadow pipe runs in lockstep with the
// multiplier's ce-qualified stages, so every product leaves on a single tagged
// result port. Result backpressure freezes the whole multiplier pipe.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset      : synchronous, active-low reset (0 = reset)
//   req_valid  : [N]        per-requester operand valid
//   req_ready  : [N]        per-requester accept, one-hot or zero
//   req_a      : [N*A_W]    operand A, requester i at [i*A_W +: A_W]
//   req_b      : [N*B_W]    operand B, requester i at [i*B_W +: B_W]
//   mul_ce     : multiplier clock enable
//   mul_din0   : [A_W]      multiplier operand 0
//   mul_din1   : [B_W]      multiplier operand 1
//   mul_dout   : [P_W]      registered multiplier product
//   res_valid  : result valid
//   res_ready  : result consumer accept
//   res_tag    : [TAG_W]    requester that owns res_data
//   res_data   : [P_W]      product, passed through from mul_dout
//   inflight   : [3]        valid entries in the shadow pipe
// -----------------------------------------------------------------------------
module encode_mul_arbiter #(
  parameter int N       = 4,
  parameter int A_W     = 40,
  parameter int B_W     = 29,
  parameter int P_W     = 68,
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*A_W-1:0]   req_a,
  input  logic [N*B_W-1:0]   req_b,
  output logic               mul_ce,
  output logic [A_W-1:0]     mul_din0,
  output logic [B_W-1:0]     mul_din1,
  input  logic [P_W-1:0]     mul_dout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [TAG_W-1:0]   res_tag,
  output logic [P_W-1:0]     res_data,
  output logic [2:0]         inflight
);

  // Round-robin pointer: the first requester examined in the next scan.
  logic [TAG_W-1:0] ptr;

  // Shadow pipe, one {v, tag} entry per multiplier register stage.
  logic [MUL_LAT-1:0] v_q;
  logic [TAG_W-1:0]   tag_q [MUL_LAT];
  logic [MUL_LAT-1:0] v_next;

  logic             grant_valid;
  logic [TAG_W-1:0] grant_idx;

  function automatic logic [TAG_W-1:0] wrap_idx(input int v);
    return TAG_W'(v % N);
  endfunction

  // The pipe advances whenever the last stage is empty or being drained; there
  // is no skid buffer, so a stalled result freezes every stage at once.
  assign res_valid = v_q[MUL_LAT-1];
  assign res_tag   = tag_q[MUL_LAT-1];
  assign res_data  = mul_dout;
  assign mul_ce    = reset & (~res_valid | res_ready);

  // Grants are only issued on cycles where the pipe moves, so an accepted
  // operand pair always lands in stage 0 on the same edge.
  assign grant_valid = (|req_valid) & mul_ce;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned and no latch is inferred.
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      // Scanning from the far end means the lowest offset from ptr wins.
      if (req_valid[wrap_idx(int'(ptr) + k)]) grant_idx = wrap_idx(int'(ptr) + k);
    end
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0 = req_a[grant_idx*A_W +: A_W];
      mul_din1 = req_b[grant_idx*B_W +: B_W];
    end
  end

  always_comb begin
    v_next    = '0;
    v_next[0] = grant_valid;
    for (int s = 1; s < MUL_LAT; s++) v_next[s] = v_q[s-1];
  end

  // Control state: valid bits, occupancy and the arbitration pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      v_q      <= '0;
      inflight <= '0;
      ptr      <= '0;
    end else begin
      if (mul_ce) begin
        v_q      <= v_next;
        inflight <= 3'($countones(v_next));
      end
      if (grant_valid) begin
        ptr <= (grant_idx == TAG_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // NOTE: tags are payload qualified by v_q, so they carry no reset; a cleared
  // valid bit is enough to make any stale tag meaningless.
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      tag_q[0] <= grant_idx;
      for (int s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

endmodule

// File: tb/tb_encode_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_encode_mul_arbiter
//
// Directed bench for encode_mul_arbiter with default parameters. A one-stage
// signed multiplier model sits on the mul_* port. Inputs change 1 time unit
// after the rising edge; outputs are checked away from the edge.
// -----------------------------------------------------------------------------
module tb_encode_mul_arbiter;

  localparam int N       = 4;
  localparam int A_W     = 40;
  localparam int B_W     = 29;
  localparam int P_W     = 68;
  localparam int MUL_LAT = 1;
  localparam int TAG_W   = 2;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*A_W-1:0]   req_a;
  logic [N*B_W-1:0]   req_b;
  logic               mul_ce;
  logic [A_W-1:0]     mul_din0;
  logic [B_W-1:0]     mul_din1;
  logic [P_W-1:0]     mul_dout;
  logic               res_valid;
  logic               res_ready;
  logic [TAG_W-1:0]   res_tag;
  logic [P_W-1:0]     res_data;
  logic [2:0]         inflight;

  int total = 0;
  int bad   = 0;

  encode_mul_arbiter #(
    .N(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_data(res_data),
    .inflight(inflight)
  );

  // Signed multiplier model: one ce-qualified register stage, product
  // truncated to P_W bits.
  logic signed [A_W+B_W-1:0] prod;
  assign prod = $signed(mul_din0) * $signed(mul_din1);
  always @(posedge clk) if (mul_ce) mul_dout <= prod[P_W-1:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  initial begin : stim
    logic             exp_v;
    logic [P_W-1:0]   exp_d;
    logic             exp_ce;
    int               k;
    int               next_out;

    // Reset with all requesters asserting: nothing may be accepted.
    reset     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    step();
    step();
    check("rst_res_valid", P_W'(res_valid), '0);
    check("rst_inflight",  P_W'(inflight),  '0);
    check("rst_req_ready", P_W'(req_ready), '0);
    check("rst_mul_ce",    P_W'(mul_ce),    '0);
    check("rst_din0",      P_W'(mul_din0),  '0);
    check("rst_din1",      P_W'(mul_din1),  '0);

    // Single request: 3 * -5.
    reset     = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 40'd3, -29'sd5);
    #1;
    check("single_ready", P_W'(req_ready), 68'h1);
    check("single_din0",  P_W'(mul_din0),  68'd3);
    step();
    req_valid = '0;
    check("single_valid",    P_W'(res_valid), 68'h1);
    check("single_tag",      P_W'(res_tag),   68'h0);
    check("single_data",     res_data,        -68'sd15);
    check("single_inflight", P_W'(inflight),  68'd1);
    step();
    check("single_drain_valid",    P_W'(res_valid), 68'h0);
    check("single_drain_inflight", P_W'(inflight),  68'd0);

    // Reset pulse puts ptr back at 0 before the fairness run.
    reset = 1'b0;
    step();
    reset = 1'b1;

    // Round robin with all four requesting: operand a = 10+i, b = 1.
    for (int i = 0; i < N; i++) set_req(i, 40'(10 + i), 29'd1);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr_ready_%0d", c), P_W'(req_ready), P_W'(4'b0001 << (c % 4)));
      step();
      check($sformatf("rr_tag_%0d", c),  P_W'(res_tag), P_W'(c % 4));
      check($sformatf("rr_data_%0d", c), res_data,      P_W'(10 + c % 4));
    end
    req_valid = '0;
    step();

    // Backpressure: requester 2 streams a=k, b=2; res_ready low in cycles 3..5.
    exp_v    = 1'b0;
    exp_d    = '0;
    k        = 1;
    next_out = 1;
    for (int c = 0; c < 12; c++) begin
      res_ready = !(c >= 3 && c <= 5);
      req_valid = (k <= 6) ? 4'b0100 : 4'b0000;
      set_req(2, 40'(k), 29'd2);
      #1;
      exp_ce = !exp_v || res_ready;
      check($sformatf("bp_ce_%0d", c),    P_W'(mul_ce),    P_W'(exp_ce));
      check($sformatf("bp_ready_%0d", c), P_W'(req_ready), (exp_ce && k <= 6) ? 68'h4 : 68'h0);
      check($sformatf("bp_valid_%0d", c), P_W'(res_valid), P_W'(exp_v));
      if (exp_v) begin
        check($sformatf("bp_tag_%0d", c),  P_W'(res_tag), 68'd2);
        check($sformatf("bp_data_%0d", c), res_data,      exp_d);
        if (res_ready) next_out++;
      end
      if (exp_ce) begin
        exp_v = (k <= 6);
        exp_d = P_W'(2 * k);
        if (k <= 6) k++;
      end
      step();
    end
    res_ready = 1'b1;

    // Signed extremes: -2^39 * -2^28 wraps to bit 67 only; (2^39-1) * -1.
    req_valid = 4'b0001;
    set_req(0, 40'h80_0000_0000, 29'h1000_0000);
    #1;
    check("ext_ready", P_W'(req_ready), 68'h1);
    step();
    check("ext_min_data", res_data, 68'h8_0000_0000_0000_0000);
    set_req(0, 40'h7F_FFFF_FFFF, 29'h1FFF_FFFF);
    step();
    req_valid = '0;
    check("ext_max_data", res_data, 68'h0 - 68'h7F_FFFF_FFFF);
    check("ext_max_tag",  P_W'(res_tag), 68'h0);
    step();

    // Reset mid-flight: hold one result stalled, then reset for one cycle.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 40'd7, 29'd3);
    #1;
    check("mid_ready", P_W'(req_ready), 68'h2);
    step();
    req_valid = '0;
    check("mid_inflight", P_W'(inflight),  68'd1);
    check("mid_valid",    P_W'(res_valid), 68'h1);
    check("mid_stall_ce", P_W'(mul_ce),    68'h0);
    reset = 1'b0;
    step();
    check("mid_rst_valid",    P_W'(res_valid), 68'h0);
    check("mid_rst_inflight", P_W'(inflight),  68'd0);
    // ptr was 2 before reset; requester 1 winning over 3 shows it returned to 0.
    reset     = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b1010;
    set_req(3, 40'd5, 29'd5);
    #1;
    check("mid_post_ready", P_W'(req_ready), 68'h2);
    check("mid_post_ce",    P_W'(mul_ce),    68'h1);
    step();
    req_valid = '0;
    check("mid_post_tag",   P_W'(res_tag),   68'd1);
    check("mid_post_data",  res_data,        68'd21);

    // Pointer skip: ptr=2 -> grant 2 (ptr 3); again 0100 -> grant 2 (ptr 3);
    // 1001 -> grant 3 (ptr 0); 1001 -> grant 0.
    req_valid = 4'b0100;
    #1;
    check("skip_ready_a", P_W'(req_ready), 68'h4);
    step();
    #1;
    check("skip_ready_b", P_W'(req_ready), 68'h4);
    step();
    req_valid = 4'b1001;
    #1;
    check("skip_ready_c", P_W'(req_ready), 68'h8);
    step();
    #1;
    check("skip_ready_d", P_W'(req_ready), 68'h1);
    step();
    req_valid = '0;
    step();
    step();
    check("final_inflight", P_W'(inflight), 68'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
